cfu_resp_scoreboard: RTL and testbench

CFU_RESP_SCOREBOARD -- requirements
Module: cfu_resp_scoreboard

---
 rtl/cfu_sb_pkg.sv | 21 ++
 rtl/cfu_sb_fifo.sv | 47 ++++
 rtl/cfu_resp_scoreboard.sv | 141 ++++++++++++++
 tb/tb_cfu_resp_scoreboard.sv | 322 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cfu_sb_pkg.sv
// Shared constants and helpers for the CFU response scoreboard.
// Holds counter width/saturation, default sizing and the compare-result encoding.
package cfu_sb_pkg;

    localparam int          SB_CNT_W           = 16;
    localparam logic [15:0] SB_CNT_SAT         = 16'hFFFF;
    localparam int          SB_DEFAULT_DEPTH   = 8;
    localparam int          SB_DEFAULT_TIMEOUT = 255;

    typedef enum logic [1:0] {
        CMP_NONE  = 2'd0,
        CMP_PASS  = 2'd1,
        CMP_FAIL  = 2'd2,
        CMP_UNEXP = 2'd3
    } cmp_e;

    function automatic logic [SB_CNT_W-1:0] sat_inc(input logic [SB_CNT_W-1:0] v);
        return (v == SB_CNT_SAT) ? v : v + 1'b1;
    endfunction

endpackage

// File: rtl/cfu_sb_fifo.sv
// In-order FIFO of expected entries; pointers carry one extra wrap bit so
// full and empty are distinguishable when the index bits are equal.
module cfu_sb_fifo #(
    parameter int W     = 38,
    parameter int DEPTH = 8
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       push,
    input  logic                       pop,
    input  logic [W-1:0]               wdata,
    output logic [W-1:0]               rdata,
    output logic                       full,
    output logic                       empty,
    output logic [$clog2(DEPTH):0]     count
);

    localparam int AW = $clog2(DEPTH);

    logic [W-1:0] mem [DEPTH];
    logic [AW:0]  wptr;
    logic [AW:0]  rptr;

    // NOTE: storage has no reset; the pointers alone decide which words are valid.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wptr[AW-1:0]] <= wdata;
        end
    end

    // NOTE: sequential state uses <= so every flop samples the pre-edge values.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wptr <= '0;
            rptr <= '0;
        end else begin
            if (push) wptr <= wptr + 1'b1;
            if (pop)  rptr <= rptr + 1'b1;
        end
    end

    assign rdata = mem[rptr[AW-1:0]];
    assign empty = (wptr == rptr);
    assign full  = (wptr[AW] != rptr[AW]) && (wptr[AW-1:0] == rptr[AW-1:0]);
    assign count = wptr - rptr;

endmodule

// File: rtl/cfu_resp_scoreboard.sv
// Scoreboard matching CFU responses in order against expected entries.
// Optional first-failure capture ports are enabled by defining CFU_SB_CAPTURE_EN.
module cfu_resp_scoreboard
    import cfu_sb_pkg::*;
#(
    parameter int CFU_REQ_RESP_ID_W = 6,
    parameter int CFU_RESP_DATA_W   = 32,
    parameter int DEPTH             = SB_DEFAULT_DEPTH,
    parameter int TIMEOUT           = SB_DEFAULT_TIMEOUT
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         exp_valid,
    output logic                         exp_ready,
    input  logic [CFU_REQ_RESP_ID_W-1:0] exp_id,
    input  logic [CFU_RESP_DATA_W-1:0]   exp_data,
    input  logic                         resp_valid,
    output logic                         resp_ready,
    input  logic [CFU_REQ_RESP_ID_W-1:0] resp_id,
    input  logic [CFU_RESP_DATA_W-1:0]   resp_data,
    output logic [SB_CNT_W-1:0]          pass_count,
    output logic [SB_CNT_W-1:0]          fail_count,
    output logic [$clog2(DEPTH):0]       outstanding,
    output logic                         mismatch,
    output logic                         timeout,
    output logic                         unexpected
`ifdef CFU_SB_CAPTURE_EN
   ,output logic                         first_fail_valid,
    output logic [CFU_REQ_RESP_ID_W-1:0] first_fail_id,
    output logic [CFU_RESP_DATA_W-1:0]   first_fail_exp,
    output logic [CFU_RESP_DATA_W-1:0]   first_fail_got
`endif
);

    localparam int E_W   = CFU_REQ_RESP_ID_W + CFU_RESP_DATA_W;
    localparam int TMO_W = $clog2(TIMEOUT + 1);

    logic                         ready_q;
    logic                         push;
    logic                         resp_fire;
    logic                         bypass;
    logic                         fifo_full;
    logic                         fifo_empty;
    logic [E_W-1:0]               fifo_rdata;
    logic [CFU_REQ_RESP_ID_W-1:0] ref_id;
    logic [CFU_RESP_DATA_W-1:0]   ref_data;
    logic [TMO_W-1:0]             tmo_cnt;
    cmp_e                         cmp_res;

    assign exp_ready  = ready_q && !fifo_full;
    assign resp_ready = ready_q;
    assign push       = exp_valid && exp_ready;
    assign resp_fire  = resp_valid && resp_ready;
    // An empty FIFO lets a same-cycle push feed the response directly.
    assign bypass     = push && resp_fire && fifo_empty;

    cfu_sb_fifo #(
        .W     (E_W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (push && !bypass),
        .pop   (resp_fire && !fifo_empty),
        .wdata ({exp_id, exp_data}),
        .rdata (fifo_rdata),
        .full  (fifo_full),
        .empty (fifo_empty),
        .count (outstanding)
    );

    // NOTE: every output of this block gets a default first, so no path infers a latch.
    always_comb begin
        ref_id   = fifo_rdata[E_W-1:CFU_RESP_DATA_W];
        ref_data = fifo_rdata[CFU_RESP_DATA_W-1:0];
        cmp_res  = CMP_NONE;
        if (bypass) begin
            ref_id   = exp_id;
            ref_data = exp_data;
        end
        if (resp_fire) begin
            if (fifo_empty && !push) begin
                cmp_res = CMP_UNEXP;
            end else if (ref_id == resp_id && ref_data == resp_data) begin
                cmp_res = CMP_PASS;
            end else begin
                cmp_res = CMP_FAIL;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ready_q    <= 1'b0;
            pass_count <= '0;
            fail_count <= '0;
            mismatch   <= 1'b0;
            unexpected <= 1'b0;
            timeout    <= 1'b0;
            tmo_cnt    <= '0;
        end else begin
            ready_q  <= 1'b1;
            mismatch <= (cmp_res == CMP_FAIL) || (cmp_res == CMP_UNEXP);
            if (cmp_res == CMP_PASS) begin
                pass_count <= sat_inc(pass_count);
            end
            if (cmp_res == CMP_FAIL || cmp_res == CMP_UNEXP) begin
                fail_count <= sat_inc(fail_count);
            end
            if (cmp_res == CMP_UNEXP) begin
                unexpected <= 1'b1;
            end
            // Idle counter only runs while something is outstanding and unanswered.
            if (resp_fire || fifo_empty) begin
                tmo_cnt <= '0;
            end else if (tmo_cnt != TMO_W'(TIMEOUT)) begin
                tmo_cnt <= tmo_cnt + 1'b1;
                if (tmo_cnt == TMO_W'(TIMEOUT - 1)) begin
                    timeout <= 1'b1;
                end
            end
        end
    end

`ifdef CFU_SB_CAPTURE_EN
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            first_fail_valid <= 1'b0;
            first_fail_id    <= '0;
            first_fail_exp   <= '0;
            first_fail_got   <= '0;
        end else if (!first_fail_valid && (cmp_res == CMP_FAIL || cmp_res == CMP_UNEXP)) begin
            first_fail_valid <= 1'b1;
            first_fail_id    <= resp_id;
            first_fail_exp   <= (cmp_res == CMP_UNEXP) ? '0 : ref_data;
            first_fail_got   <= resp_data;
        end
    end
`endif

endmodule

// File: tb/tb_cfu_resp_scoreboard.sv
// Self-checking bench for cfu_resp_scoreboard: directed scenarios then random traffic
// against a queue-based reference model. Optional CFU_SB_CAPTURE_EN checks capture ports.
module tb_cfu_resp_scoreboard;

    localparam int ID_W    = 6;
    localparam int DW      = 32;
    localparam int DEPTH   = 8;
    localparam int TIMEOUT = 255;

    typedef struct packed {
        logic [ID_W-1:0] id;
        logic [DW-1:0]   data;
    } ent_t;

    logic            clk = 1'b0;
    logic            rst;
    logic            exp_valid;
    logic            exp_ready;
    logic [ID_W-1:0] exp_id;
    logic [DW-1:0]   exp_data;
    logic            resp_valid;
    logic            resp_ready;
    logic [ID_W-1:0] resp_id;
    logic [DW-1:0]   resp_data;
    logic [15:0]     pass_count;
    logic [15:0]     fail_count;
    logic [3:0]      outstanding;
    logic            mismatch;
    logic            timeout;
    logic            unexpected;
`ifdef CFU_SB_CAPTURE_EN
    logic            first_fail_valid;
    logic [ID_W-1:0] first_fail_id;
    logic [DW-1:0]   first_fail_exp;
    logic [DW-1:0]   first_fail_got;
`endif

    cfu_resp_scoreboard #(
        .CFU_REQ_RESP_ID_W (ID_W),
        .CFU_RESP_DATA_W   (DW),
        .DEPTH             (DEPTH),
        .TIMEOUT           (TIMEOUT)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .exp_valid   (exp_valid),
        .exp_ready   (exp_ready),
        .exp_id      (exp_id),
        .exp_data    (exp_data),
        .resp_valid  (resp_valid),
        .resp_ready  (resp_ready),
        .resp_id     (resp_id),
        .resp_data   (resp_data),
        .pass_count  (pass_count),
        .fail_count  (fail_count),
        .outstanding (outstanding),
        .mismatch    (mismatch),
        .timeout     (timeout),
        .unexpected  (unexpected)
`ifdef CFU_SB_CAPTURE_EN
       ,.first_fail_valid (first_fail_valid),
        .first_fail_id    (first_fail_id),
        .first_fail_exp   (first_fail_exp),
        .first_fail_got   (first_fail_got)
`endif
    );

    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    // Reference model state
    ent_t        m_q[$];
    bit          m_live;
    int          m_pass;
    int          m_fail;
    bit          m_unexp;
    bit          m_tmo;
    int          m_idle;
    bit          m_ff_valid;
    logic [ID_W-1:0] m_ff_id;
    logic [DW-1:0]   m_ff_exp;
    logic [DW-1:0]   m_ff_got;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        checks++;
        assert (obs === expv) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    task automatic model_reset();
        m_q.delete();
        m_live     = 1'b0;
        m_pass     = 0;
        m_fail     = 0;
        m_unexp    = 1'b0;
        m_tmo      = 1'b0;
        m_idle     = 0;
        m_ff_valid = 1'b0;
        m_ff_id    = '0;
        m_ff_exp   = '0;
        m_ff_got   = '0;
    endtask

    task automatic record_fail(input logic [ID_W-1:0] id, input logic [DW-1:0] e, input logic [DW-1:0] g);
        if (m_fail < 16'hFFFF) m_fail++;
        if (!m_ff_valid) begin
            m_ff_valid = 1'b1;
            m_ff_id    = id;
            m_ff_exp   = e;
            m_ff_got   = g;
        end
    endtask

    // One clock cycle: drive inputs, check readiness, advance model, check outputs.
    task automatic step(input logic ev, input logic [ID_W-1:0] eid, input logic [DW-1:0] ed,
                        input logic rv, input logic [ID_W-1:0] rid, input logic [DW-1:0] rd);
        bit   do_push;
        bit   do_resp;
        bit   had;
        bit   failed;
        ent_t e;
        exp_valid  = ev;
        exp_id     = eid;
        exp_data   = ed;
        resp_valid = rv;
        resp_id    = rid;
        resp_data  = rd;
        chk("exp_ready", 64'(exp_ready), 64'(m_live && m_q.size() < DEPTH));
        chk("resp_ready", 64'(resp_ready), 64'(m_live));
        do_push = ev && m_live && (m_q.size() < DEPTH);
        do_resp = rv && m_live;
        had     = (m_q.size() > 0);
        failed  = 1'b0;
        if (do_resp) begin
            if (had) begin
                e = m_q.pop_front();
            end else if (do_push) begin
                e = '{id: eid, data: ed};
                do_push = 1'b0;
            end else begin
                e = '{id: '0, data: '0};
                m_unexp = 1'b1;
                failed = 1'b1;
                record_fail(rid, '0, rd);
            end
            if (!failed) begin
                if (e.id == rid && e.data == rd) begin
                    if (m_pass < 16'hFFFF) m_pass++;
                end else begin
                    failed = 1'b1;
                    record_fail(rid, e.data, rd);
                end
            end
        end
        if (do_push) m_q.push_back('{id: eid, data: ed});
        if (do_resp || !had) m_idle = 0;
        else m_idle++;
        if (m_idle >= TIMEOUT) m_tmo = 1'b1;
        @(posedge clk);
        #1;
        m_live = 1'b1;
        chk("outstanding", 64'(outstanding), 64'(m_q.size()));
        chk("pass_count", 64'(pass_count), 64'(m_pass));
        chk("fail_count", 64'(fail_count), 64'(m_fail));
        chk("mismatch", 64'(mismatch), 64'(failed));
        chk("unexpected", 64'(unexpected), 64'(m_unexp));
        chk("timeout", 64'(timeout), 64'(m_tmo));
`ifdef CFU_SB_CAPTURE_EN
        chk("ff_valid", 64'(first_fail_valid), 64'(m_ff_valid));
        if (m_ff_valid) begin
            chk("ff_id", 64'(first_fail_id), 64'(m_ff_id));
            chk("ff_exp", 64'(first_fail_exp), 64'(m_ff_exp));
            chk("ff_got", 64'(first_fail_got), 64'(m_ff_got));
        end
`endif
    endtask

    task automatic idle_step();
        step(1'b0, '0, '0, 1'b0, '0, '0);
    endtask

    task automatic push_only(input logic [ID_W-1:0] id, input logic [DW-1:0] d);
        step(1'b1, id, d, 1'b0, '0, '0);
    endtask

    task automatic resp_only(input logic [ID_W-1:0] id, input logic [DW-1:0] d);
        step(1'b0, '0, '0, 1'b1, id, d);
    endtask

    // Asynchronous reset applied between edges, checked before any edge follows.
    task automatic apply_reset();
        #1;
        rst = 1'b0;
        #1;
        model_reset();
        chk("rst_outstanding", 64'(outstanding), 64'd0);
        chk("rst_exp_ready", 64'(exp_ready), 64'd0);
        chk("rst_resp_ready", 64'(resp_ready), 64'd0);
        chk("rst_flags", 64'({mismatch, timeout, unexpected}), 64'd0);
        chk("rst_counts", 64'({pass_count, fail_count}), 64'd0);
        exp_valid  = 1'b0;
        resp_valid = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_hold_ready", 64'({exp_ready, resp_ready}), 64'd0);
        rst = 1'b1;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog expired checks=%0d failures=%0d", checks, failures);
        $fatal(1, "watchdog");
    end

    initial begin
        rst        = 1'b1;
        exp_valid  = 1'b0;
        exp_id     = '0;
        exp_data   = '0;
        resp_valid = 1'b0;
        resp_id    = '0;
        resp_data  = '0;
        model_reset();
        @(posedge clk);
        apply_reset();

        // First cycle after release: not yet ready; ready after the first edge.
        idle_step();
        chk("ready_after_rst", 64'({exp_ready, resp_ready}), 64'b11);

        // Matching pair.
        push_only(6'd3, 32'h0000_0010);
        resp_only(6'd3, 32'h0000_0010);
        chk("pair_pass", 64'(pass_count), 64'd1);
        chk("pair_outstanding", 64'(outstanding), 64'd0);

        // Data mismatch: single mismatch pulse.
        push_only(6'd5, 32'hDEAD_BEEF);
        resp_only(6'd5, 32'hDEAD_BEEE);
        chk("mm_fail", 64'(fail_count), 64'd1);
        chk("mm_pulse", 64'(mismatch), 64'd1);
`ifdef CFU_SB_CAPTURE_EN
        chk("mm_got", 64'(first_fail_got), 64'h0000_0000_DEAD_BEEE);
`endif
        idle_step();
        chk("mm_pulse_end", 64'(mismatch), 64'd0);

        // Fill to full, hold off a 9th push, free one slot, then accept it.
        for (int i = 0; i < DEPTH; i++) push_only(6'(10 + i), 32'(100 + i));
        chk("full_outstanding", 64'(outstanding), 64'd8);
        chk("full_ready", 64'(exp_ready), 64'd0);
        push_only(6'd30, 32'h3030);
        chk("held_outstanding", 64'(outstanding), 64'd8);
        step(1'b1, 6'd30, 32'h3030, 1'b1, 6'd10, 32'd100);
        chk("slot_free", 64'(outstanding), 64'd7);
        push_only(6'd30, 32'h3030);
        chk("late_push", 64'(outstanding), 64'd8);
        for (int i = 1; i < DEPTH; i++) resp_only(6'(10 + i), 32'(100 + i));
        resp_only(6'd30, 32'h3030);
        chk("drained", 64'(outstanding), 64'd0);

        // Bypass with empty FIFO.
        step(1'b1, 6'd7, 32'h1, 1'b1, 6'd7, 32'h1);
        chk("bypass_outstanding", 64'(outstanding), 64'd0);

        // Random traffic; responses usually target the model's head entry.
        for (int n = 0; n < 400; n++) begin
            logic            ev;
            logic            rv;
            logic [ID_W-1:0] eid;
            logic [DW-1:0]   ed;
            logic [ID_W-1:0] rid;
            logic [DW-1:0]   rd;
            ev  = 1'($urandom_range(1));
            rv  = ($urandom_range(99) < 45);
            eid = 6'($urandom_range(63));
            ed  = $urandom();
            rid = 6'($urandom_range(63));
            rd  = $urandom();
            if ($urandom_range(99) < 80) begin
                if (m_q.size() > 0) begin
                    rid = m_q[0].id;
                    rd  = m_q[0].data;
                end else if (ev) begin
                    rid = eid;
                    rd  = ed;
                end
            end
            step(ev, eid, ed, rv, rid, rd);
        end
        while (m_q.size() > 0) resp_only(m_q[0].id, m_q[0].data);

        // Unexpected response, then timeout with one entry left unanswered.
        apply_reset();
        idle_step();
        resp_only(6'd9, 32'h99);
        chk("unexp_flag", 64'(unexpected), 64'd1);
        chk("unexp_fail", 64'(fail_count), 64'd1);
        push_only(6'd4, 32'h44);
        repeat (250) idle_step();
        chk("tmo_early", 64'(timeout), 64'd0);
        repeat (6) idle_step();
        chk("tmo_set", 64'(timeout), 64'd1);

        // Reset mid-operation with four outstanding.
        for (int i = 0; i < 3; i++) push_only(6'(20 + i), 32'(200 + i));
        chk("four_outstanding", 64'(outstanding), 64'd4);
        apply_reset();
        idle_step();
        resp_only(6'd20, 32'd200);
        chk("post_rst_unexp", 64'(unexpected), 64'd1);
        chk("post_rst_fail", 64'(fail_count), 64'd1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
